// File: rtl/req_grnt_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : req_grnt_pkg
//  Description : Shared types and helpers for the round-robin req/grnt arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package req_grnt_pkg;

    // Arbiter FSM states: IDLE picks an owner, WAIT models the req->grnt
    // latency, GRANT holds the resource, REL forces the idle gap.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        GRANT = 2'd2,
        REL   = 2'd3
    } arb_state_t;

    // Bit n of the one-hot code of idx; callers loop n over the vector width
    // so the result never carries unused upper bits.
    function automatic logic onehot_f(input int unsigned idx, input int unsigned n);
        return (idx == n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/req_grnt_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin search: first set request bit at or
//                after ptr, wrapping from N-1 back to 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          found,
    output logic [IW-1:0] idx
);

    // Walk offsets 0..N-1 from ptr; the first hit wins.
    always_comb begin
        int          p;
        logic [IW-1:0] pos;
        found = 1'b0;
        idx   = '0;
        p     = 0;
        pos   = '0;
        for (int i = 0; i < N; i++) begin
            p = int'(ptr) + i;
            if (p >= N) begin
                p = p - N;
            end
            pos = IW'(p);
            if (!found && req[pos]) begin
                found = 1'b1;
                idx   = pos;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/req_grnt_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : req_grnt_arbiter
//  Description : Round-robin arbiter for NUM_REQ requesters with a fixed
//                req->grnt latency, bounded grant hold and a one-cycle idle
//                gap (REL) after every grant. All outputs are registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module req_grnt_arbiter
    import req_grnt_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int GNT_DELAY = 2,
    parameter int MAX_HOLD  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    output logic [NUM_REQ-1:0]         grnt,
    output logic [$clog2(NUM_REQ)-1:0] grnt_id,
    output logic                       busy,
    output logic                       timeout
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam int DW = $clog2(GNT_DELAY + 1);

    localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_REQ - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD);
    localparam logic [DW-1:0] DLY_LAST  = DW'(GNT_DELAY - 1);

    arb_state_t          state_q,    state_d;
    logic [NUM_REQ-1:0]  grnt_q,     grnt_d;
    logic [IW-1:0]       grnt_id_q,  grnt_id_d;
    logic                busy_q,     busy_d;
    logic                timeout_q,  timeout_d;
    logic [IW-1:0]       rr_ptr_q,   rr_ptr_d;
    logic [HW-1:0]       hold_cnt_q, hold_cnt_d;
    logic [DW-1:0]       dly_cnt_q,  dly_cnt_d;

    logic                pick_found;
    logic [IW-1:0]       pick_idx;
    logic [IW-1:0]       sel_idx;
    logic [NUM_REQ-1:0]  sel_oh;
    logic                own_req;
    logic [IW-1:0]       next_ptr;

    rr_pick #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_rr_pick (
        .req   (req),
        .ptr   (rr_ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // One-hot of the requester about to be granted: the fresh pick when the
    // grant is issued straight from IDLE, otherwise the latched owner.
    always_comb begin
        sel_idx  = (state_q == IDLE) ? pick_idx : grnt_id_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            sel_oh[i] = onehot_f(32'(sel_idx), i);
        end
        own_req  = req[grnt_id_q];
        next_ptr = (grnt_id_q == LAST_IDX) ? '0 : grnt_id_q + IW'(1);
    end

    // Next-state and next-output computation for the arbiter FSM.
    always_comb begin
        state_d    = state_q;
        grnt_d     = grnt_q;
        grnt_id_d  = grnt_id_q;
        timeout_d  = 1'b0;
        rr_ptr_d   = rr_ptr_q;
        hold_cnt_d = hold_cnt_q;
        dly_cnt_d  = dly_cnt_q;

        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grnt_id_d = pick_idx;
                    if (GNT_DELAY > 1) begin
                        state_d   = WAIT;
                        dly_cnt_d = DW'(1);
                    end else begin
                        state_d    = GRANT;
                        grnt_d     = sel_oh;
                        hold_cnt_d = HW'(1);
                    end
                end
            end
            WAIT: begin
                if (!own_req) begin
                    // Owner withdrew before the grant: skip past it.
                    state_d   = IDLE;
                    rr_ptr_d  = next_ptr;
                    dly_cnt_d = '0;
                end else if (dly_cnt_q == DLY_LAST) begin
                    state_d    = GRANT;
                    grnt_d     = sel_oh;
                    hold_cnt_d = HW'(1);
                    dly_cnt_d  = '0;
                end else begin
                    dly_cnt_d = dly_cnt_q + DW'(1);
                end
            end
            GRANT: begin
                // A req drop takes priority, so a simultaneous hold expiry
                // releases without a timeout pulse.
                if (!own_req) begin
                    state_d  = REL;
                    grnt_d   = '0;
                    rr_ptr_d = next_ptr;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    state_d   = REL;
                    grnt_d    = '0;
                    rr_ptr_d  = next_ptr;
                    timeout_d = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + HW'(1);
                end
            end
            REL: begin
                state_d    = IDLE;
                hold_cnt_d = '0;
            end
            default: begin
                state_d = IDLE;
                grnt_d  = '0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset wins over every other event.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            grnt_q     <= '0;
            grnt_id_q  <= '0;
            busy_q     <= 1'b0;
            timeout_q  <= 1'b0;
            rr_ptr_q   <= '0;
            hold_cnt_q <= '0;
            dly_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            grnt_q     <= grnt_d;
            grnt_id_q  <= grnt_id_d;
            busy_q     <= busy_d;
            timeout_q  <= timeout_d;
            rr_ptr_q   <= rr_ptr_d;
            hold_cnt_q <= hold_cnt_d;
            dly_cnt_q  <= dly_cnt_d;
        end
    end

    assign grnt    = grnt_q;
    assign grnt_id = grnt_id_q;
    assign busy    = busy_q;
    assign timeout = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_req_grnt_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_req_grnt_arbiter
//  Description : Directed self-checking bench for req_grnt_arbiter, default
//                parameters plus a minimal-latency 3-requester instance.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_req_grnt_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req0, grnt0;
    logic [1:0] id0;
    logic       busy0, to0;
    logic [2:0] req1, grnt1;
    logic [1:0] id1;
    logic       busy1, to1;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    req_grnt_arbiter #(.NUM_REQ(4), .GNT_DELAY(2), .MAX_HOLD(8)) u_dut0 (
        .clk     (clk),
        .rst     (rst),
        .req     (req0),
        .grnt    (grnt0),
        .grnt_id (id0),
        .busy    (busy0),
        .timeout (to0)
    );

    req_grnt_arbiter #(.NUM_REQ(3), .GNT_DELAY(1), .MAX_HOLD(1)) u_dut1 (
        .clk     (clk),
        .rst     (rst),
        .req     (req1),
        .grnt    (grnt1),
        .grnt_id (id1),
        .busy    (busy1),
        .timeout (to1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst  = 1'b1;
        req0 = '0;
        req1 = '0;
        tick();
        tick();
        chk("rst_grnt",    32'(grnt0), 32'h0);
        chk("rst_busy",    32'(busy0), 32'h0);
        chk("rst_id",      32'(id0),   32'h0);
        chk("rst_timeout", 32'(to0),   32'h0);
        rst = 1'b0;

        // 1. Single request: two-cycle latency, release on req drop.
        req0 = 4'b0010;
        tick();
        chk("t1_wait_busy", 32'(busy0), 32'h1);
        chk("t1_wait_grnt", 32'(grnt0), 32'h0);
        chk("t1_wait_id",   32'(id0),   32'h1);
        tick();
        chk("t1_grant_c1",  32'(grnt0), 32'h2);
        tick();
        tick();
        chk("t1_grant_c3",  32'(grnt0), 32'h2);
        req0 = 4'b0000;
        tick();
        chk("t1_rel_grnt",  32'(grnt0), 32'h0);
        chk("t1_rel_busy",  32'(busy0), 32'h1);
        chk("t1_rel_to",    32'(to0),   32'h0);
        tick();
        chk("t1_idle_busy", 32'(busy0), 32'h0);

        // 2. All requesting: rotation 0,1,2,3,0 with 8-cycle grants.
        rst = 1'b1;
        tick();
        rst  = 1'b0;
        req0 = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            tick();
            chk("t2_wait_id",   32'(id0),   32'(g % 4));
            chk("t2_wait_grnt", 32'(grnt0), 32'h0);
            tick();
            chk("t2_grant_c1",  32'(grnt0), 32'(1 << (g % 4)));
            repeat (7) tick();
            chk("t2_grant_c8",  32'(grnt0), 32'(1 << (g % 4)));
            chk("t2_grant_to",  32'(to0),   32'h0);
            tick();
            chk("t2_rel_grnt",  32'(grnt0), 32'h0);
            chk("t2_rel_to",    32'(to0),   32'h1);
            tick();
            chk("t2_idle_to",   32'(to0),   32'h0);
            chk("t2_idle_busy", 32'(busy0), 32'h0);
        end

        // 3. Abort in WAIT, then wrap of the round-robin pointer 3 -> 0.
        req0 = 4'b0100;
        tick();
        chk("t3_wait_id",    32'(id0),   32'h2);
        chk("t3_wait_busy",  32'(busy0), 32'h1);
        req0 = 4'b0000;
        tick();
        chk("t3_abort_busy", 32'(busy0), 32'h0);
        chk("t3_abort_grnt", 32'(grnt0), 32'h0);
        req0 = 4'b0101;
        tick();
        chk("t3_wrap_id",    32'(id0),   32'h0);
        tick();
        chk("t3_wrap_grnt",  32'(grnt0), 32'h1);

        // 4. req drop on the same edge the hold limit is reached.
        repeat (7) tick();
        chk("t4_grant_c8", 32'(grnt0), 32'h1);
        req0 = 4'b0000;
        tick();
        chk("t4_rel_grnt", 32'(grnt0), 32'h0);
        chk("t4_rel_to",   32'(to0),   32'h0);
        chk("t4_rel_busy", 32'(busy0), 32'h1);
        tick();
        chk("t4_idle_busy", 32'(busy0), 32'h0);

        // 5. Reset in the middle of a grant to requester 3.
        req0 = 4'b1000;
        tick();
        chk("t5_wait_id",  32'(id0),   32'h3);
        tick();
        chk("t5_grant",    32'(grnt0), 32'h8);
        tick();
        rst = 1'b1;
        tick();
        chk("t5_rst_grnt", 32'(grnt0), 32'h0);
        chk("t5_rst_busy", 32'(busy0), 32'h0);
        chk("t5_rst_id",   32'(id0),   32'h0);
        chk("t5_rst_to",   32'(to0),   32'h0);
        rst  = 1'b0;
        req0 = 4'b1001;
        tick();
        chk("t5_next_id",   32'(id0),   32'h0);
        tick();
        chk("t5_next_grnt", 32'(grnt0), 32'h1);
        req0 = 4'b0000;
        tick();
        tick();

        // 6. GNT_DELAY=1, MAX_HOLD=1, NUM_REQ=3: 1-cycle grants, wrap 2 -> 0.
        req1 = 3'b111;
        for (int g = 0; g < 4; g++) begin
            tick();
            chk("t6_grant",     32'(grnt1), 32'(1 << (g % 3)));
            chk("t6_grant_id",  32'(id1),   32'(g % 3));
            chk("t6_busy",      32'(busy1), 32'h1);
            tick();
            chk("t6_rel_grnt",  32'(grnt1), 32'h0);
            chk("t6_rel_to",    32'(to1),   32'h1);
            tick();
            chk("t6_idle_to",   32'(to1),   32'h0);
            chk("t6_idle_busy", 32'(busy1), 32'h0);
        end
        req1 = 3'b000;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
